// File: rtl/cam_frame_writer_if.sv
// Camera pin bundle plus frame-buffer write port for cam_frame_writer.
// master: the writer (reads camera pins, drives the write side).
// slave:  the camera source / frame buffer side.
interface cam_frame_writer_if;
    logic        cam_pclk;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [15:0] w_data;
    logic        w_en;
    logic [16:0] w_bufferIndex;
    logic        vsync;
    logic        frame_done;
    logic [2:0]  err;

    modport master (
        input  cam_pclk, cam_vsync, cam_href, cam_data,
        output w_data, w_en, w_bufferIndex, vsync, frame_done, err
    );

    modport slave (
        output cam_pclk, cam_vsync, cam_href, cam_data,
        input  w_data, w_en, w_bufferIndex, vsync, frame_done, err
    );
endinterface

// File: rtl/cam_frame_writer.sv
// Oversampling camera capture: synchronises the 8-bit camera port onto clk,
// pairs bytes into RGB565 pixels and drives a held-level write into the
// frame buffer with a linear pixel index.
module cam_frame_writer #(
    parameter int H_PIXELS    = 320,
    parameter int V_LINES     = 240,
    parameter int W_EN_HOLD   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    cam_frame_writer_if.master bus
);
    localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
    localparam int COL_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam int HOLD_W = $clog2(W_EN_HOLD + 1);

    localparam logic [COL_W-1:0]  COL_LIMIT   = COL_W'(H_PIXELS);
    localparam logic [COL_W-1:0]  COL_ONE     = COL_W'(1);
    localparam logic [LINE_W-1:0] LINE_LIMIT  = LINE_W'(V_LINES);
    localparam logic [LINE_W-1:0] LINE_ONE    = LINE_W'(1);
    localparam logic [16:0]       LINE_STEP   = 17'(H_PIXELS);
    localparam logic [16:0]       FRAME_LIMIT = 17'(FRAME_PIXELS);
    localparam logic [16:0]       IDX_ONE     = 17'd1;
    localparam logic [16:0]       IDX_MAX     = '1;
    localparam logic [HOLD_W-1:0] HOLD_INIT   = HOLD_W'(W_EN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    typedef enum logic [1:0] {IDLE, WAIT_START, CAPTURE} state_t;

    // Synchroniser chains; the top index is the final (stable) stage.
    logic [SYNC_STAGES-1:0]      pclk_sync_reg, vsync_sync_reg, href_sync_reg;
    logic [SYNC_STAGES-1:0][7:0] data_sync_reg;
    logic pclk_d_reg, vsync_d_reg, href_d_reg;

    logic       pclk_s, vsync_s, href_s;
    logic [7:0] data_s;
    logic       pclk_rise, vsync_rise, vsync_fall, href_fall;
    logic       byte_ev, pix_done, in_range;

    state_t              state_reg;
    logic [COL_W-1:0]    col_reg;
    logic [COL_W-1:0]    col_next;
    logic [LINE_W-1:0]   line_reg;
    logic [16:0]         line_base_reg;
    logic [16:0]         pix_count_reg;
    logic [16:0]         pix_index;
    logic                phase_lo_reg;
    logic [7:0]          hi_byte_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [15:0]         w_data_reg;
    logic [16:0]         w_index_reg;
    logic                w_en_reg;
    logic                frame_done_reg;
    logic [2:0]          err_reg;

    // Shift every camera pin through the synchroniser, then one extra stage for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pclk_sync_reg  <= '0;
            vsync_sync_reg <= '0;
            href_sync_reg  <= '0;
            data_sync_reg  <= '0;
            pclk_d_reg     <= 1'b0;
            vsync_d_reg    <= 1'b0;
            href_d_reg     <= 1'b0;
        end else begin
            pclk_sync_reg  <= {pclk_sync_reg[SYNC_STAGES-2:0], bus.cam_pclk};
            vsync_sync_reg <= {vsync_sync_reg[SYNC_STAGES-2:0], bus.cam_vsync};
            href_sync_reg  <= {href_sync_reg[SYNC_STAGES-2:0], bus.cam_href};
            data_sync_reg  <= {data_sync_reg[SYNC_STAGES-2:0], bus.cam_data};
            pclk_d_reg     <= pclk_s;
            vsync_d_reg    <= vsync_s;
            href_d_reg     <= href_s;
        end
    end

    assign pclk_s  = pclk_sync_reg[SYNC_STAGES-1];
    assign vsync_s = vsync_sync_reg[SYNC_STAGES-1];
    assign href_s  = href_sync_reg[SYNC_STAGES-1];
    assign data_s  = data_sync_reg[SYNC_STAGES-1];

    assign pclk_rise  = pclk_s & ~pclk_d_reg;
    assign vsync_rise = vsync_s & ~vsync_d_reg;
    assign vsync_fall = ~vsync_s & vsync_d_reg;
    assign href_fall  = ~href_s & href_d_reg;

    // A byte clocked in the same cycle href drops still belongs to the line.
    assign byte_ev   = pclk_rise & (href_s | href_d_reg);
    assign pix_done  = byte_ev & phase_lo_reg;
    assign in_range  = (col_reg < COL_LIMIT) && (line_reg < LINE_LIMIT);
    assign pix_index = line_base_reg + 17'(col_reg);

    // Column after this cycle's pixel, so a coincident href fall sees the new pixel.
    always_comb begin
        col_next = col_reg;
        if (pix_done && in_range) begin
            col_next = col_reg + COL_ONE;
        end
    end

    // Frame FSM, byte pairing, index bookkeeping and the held w_en level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            line_reg       <= '0;
            line_base_reg  <= '0;
            pix_count_reg  <= '0;
            phase_lo_reg   <= 1'b0;
            hi_byte_reg    <= '0;
            hold_cnt_reg   <= '0;
            w_data_reg     <= '0;
            w_index_reg    <= '0;
            w_en_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            err_reg        <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            // w_en drops when the hold count expires; a load in that same last-high
            // cycle is refused (w_en_reg still 1), which guarantees a low cycle.
            if (hold_cnt_reg != '0) begin
                hold_cnt_reg <= hold_cnt_reg - HOLD_ONE;
                if (hold_cnt_reg == HOLD_ONE) begin
                    w_en_reg <= 1'b0;
                end
            end
            case (state_reg)
                IDLE: begin
                    state_reg <= WAIT_START;
                end
                WAIT_START: begin
                    if (vsync_fall) begin
                        state_reg     <= CAPTURE;
                        col_reg       <= '0;
                        line_reg      <= '0;
                        line_base_reg <= '0;
                        pix_count_reg <= '0;
                        phase_lo_reg  <= 1'b0;
                        err_reg       <= '0;
                        w_index_reg   <= '0;
                    end
                end
                CAPTURE: begin
                    if (vsync_rise) begin
                        // Frame end outranks any byte arriving in the same cycle.
                        state_reg      <= WAIT_START;
                        frame_done_reg <= 1'b1;
                        w_index_reg    <= pix_count_reg;
                        if (pix_count_reg < FRAME_LIMIT) begin
                            err_reg[2] <= 1'b1;
                        end
                    end else begin
                        if (byte_ev && !phase_lo_reg) begin
                            hi_byte_reg  <= data_s;
                            phase_lo_reg <= 1'b1;
                        end
                        if (pix_done) begin
                            phase_lo_reg <= 1'b0;
                            if (in_range) begin
                                col_reg <= col_next;
                                if (w_en_reg) begin
                                    err_reg[0] <= 1'b1;
                                end else begin
                                    w_data_reg   <= {hi_byte_reg, data_s};
                                    w_index_reg  <= pix_index;
                                    w_en_reg     <= 1'b1;
                                    hold_cnt_reg <= HOLD_INIT;
                                    if (pix_count_reg != IDX_MAX) begin
                                        pix_count_reg <= pix_count_reg + IDX_ONE;
                                    end
                                end
                            end else begin
                                err_reg[1] <= 1'b1;
                            end
                        end
                        // Line end: drop any orphan HI byte; empty lines do not advance.
                        if (href_fall) begin
                            phase_lo_reg <= 1'b0;
                            if (col_next != '0) begin
                                col_reg <= '0;
                                if (line_reg < LINE_LIMIT) begin
                                    line_reg      <= line_reg + LINE_ONE;
                                    line_base_reg <= line_base_reg + LINE_STEP;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.w_data        = w_data_reg;
    assign bus.w_en          = w_en_reg;
    assign bus.w_bufferIndex = w_index_reg;
    assign bus.vsync         = vsync_s;
    assign bus.frame_done    = frame_done_reg;
    assign bus.err           = err_reg;
endmodule
